// File: rtl/dfg_pkg.sv
// Shared types and golden model for the double Feynman gate self-test sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dfg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } dfg_state_e;

  localparam int DFG_VEC_COUNT = 8;

  // Expected {p,q,r} for a gate input vector {a,b,c}: p=a, q=a^b, r=a^c.
  function automatic logic [2:0] dfg_golden(input logic [2:0] abc);
    return {abc[2], abc[2] ^ abc[1], abc[2] ^ abc[0]};
  endfunction

endpackage

// File: rtl/dfg_vector_sequencer.sv
// Self-test sequencer: drives all 8 {a,b,c} vectors into the gate and checks {p,q,r}.
// Latency: 2+SETTLE_CYCLES cycles per vector, done 8*(2+SETTLE_CYCLES) edges after start.
// Backpressure: none; start is ignored while busy and acts only in IDLE or DONE.
module dfg_vector_sequencer
  import dfg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             p,
  input  logic             q,
  input  logic             r,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_fail_vec,
  output logic             first_fail_valid
);

  // The settle counter needs at least one bit even when no settle time is used.
  localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  // WAIT lasts SETTLE_CYCLES cycles, so the down-counter starts one below that.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [2:0]       LAST_IDX = 3'(DFG_VEC_COUNT - 1);

  dfg_state_e       r_state;
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [ERR_W-1:0] r_err;
  logic [2:0]       r_ffvec;
  logic             r_ffv;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_next;

  // Compare the gate response against the golden model; only consumed in CHECK,
  // so X or glitches on p/q/r in any other state never reach a register.
  always_comb begin
    w_mismatch = ({p, q, r} != dfg_golden(r_idx));
    w_err_next = r_err;
    if (w_mismatch && (r_err != ERR_MAX)) begin
      w_err_next = r_err + ERR_W'(1);
    end
  end

  // Sequencer FSM with registered status outputs; the vector index doubles as {a,b,c}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= 3'd0;
      r_cnt   <= '0;
      r_err   <= '0;
      r_ffvec <= 3'd0;
      r_ffv   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= DRIVE;
            r_idx   <= 3'd0;
            r_err   <= '0;
            r_ffvec <= 3'd0;
            r_ffv   <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        DRIVE: begin
          if (SETTLE_CYCLES > 0) begin
            r_cnt   <= CNT_LOAD;
            r_state <= WAIT;
          end else begin
            r_state <= CHECK;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state <= CHECK;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        CHECK: begin
          r_err <= w_err_next;
          if (w_mismatch && !r_ffv) begin
            r_ffvec <= r_idx;
            r_ffv   <= 1'b1;
          end
          if (r_idx == LAST_IDX) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_idx   <= r_idx + 3'd1;
            r_state <= DRIVE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign a                = r_idx[2];
  assign b                = r_idx[1];
  assign c                = r_idx[0];
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err;
  assign first_fail_vec   = r_ffvec;
  assign first_fail_valid = r_ffv;

endmodule

// File: doc/dfg_vector_sequencer.md
Name: dfg_vector_sequencer

Overview:
Self-timed stimulus generator and response checker for the double Feynman gate (p = a, q = a^b, r = a^c).
- Sits directly upstream and downstream of the gate: it drives a/b/c into it and consumes p/q/r from it.
- Walks all 8 input vectors, waits a settle interval, and compares each response against the golden function.
- Reports pass/fail, an error count and the first failing vector. Used for in-system self-test of the gate.

Parameters:
SETTLE_CYCLES, 1, cycles waited after driving a vector before checking; 0 allowed
ERR_W, 4, width of the error counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  run request; sampled only in IDLE or DONE
a  output  1  gate input a, registered
b  output  1  gate input b, registered
c  output  1  gate input c, registered
p  input  1  gate output p
q  input  1  gate output q
r  input  1  gate output r
busy  output  1  run in progress
done  output  1  run complete; held until next start
pass  output  1  valid with done; 1 when no mismatches were found
err_count  output  ERR_W  mismatch count, saturating
first_fail_vec  output  3  {a,b,c} of the first mismatching vector
first_fail_valid  output  1  first_fail_vec holds a captured value

Behaviour:
- Reset: all outputs 0, state IDLE, vector index 0. Reset is asynchronous and active-low, and is honoured mid-run: everything returns to reset values immediately.
- Vector encoding: idx[2:0] = {a,b,c}, a is MSB. Order is 000 to 111.
- Golden response: {p,q,r} = {a, a^b, a^c}.
- States: IDLE, DRIVE, WAIT, CHECK, DONE.
- IDLE or DONE, start=1 at an edge:
  - Next state DRIVE; idx=0; {a,b,c}=000.
  - err_count=0, first_fail_valid=0, first_fail_vec=0.
  - busy=1, done=0, pass=0.
- DRIVE (1 cycle): {a,b,c} holds idx. Next state is WAIT if SETTLE_CYCLES>0, else CHECK.
- WAIT: lasts exactly SETTLE_CYCLES cycles (down-counter), then CHECK.
- CHECK (1 cycle): at the exiting edge, sample {p,q,r} and compare with golden(idx).
  - On mismatch: err_count increments, saturating at 2^ERR_W-1.
  - On the first mismatch only: first_fail_vec=idx and first_fail_valid=1.
- Leaving CHECK:
  - idx<7: idx++, {a,b,c}=idx+1, next state DRIVE.
  - idx==7: next state DONE; busy=0, done=1, pass=(final err_count==0), where the final count includes the current compare.
- Timing: each vector takes 2+SETTLE_CYCLES cycles. done rises 8*(2+SETTLE_CYCLES) edges after the start edge; 24 edges at the default.
- Input stability: {a,b,c} is stable from DRIVE through CHECK and changes only at the CHECK-to-DRIVE edge.
- start while busy (DRIVE/WAIT/CHECK): ignored, with no effect on state or counters.
- start in DONE: restarts immediately, with the same clearing as from IDLE.
- p/q/r: sampled only in CHECK and ignored elsewhere; X/glitches outside CHECK have no effect.
- Holds in DONE: err_count, first_fail_*, pass and done are held until the next start or reset.

Decomposition:
- Package dfg_pkg:
  - state enum dfg_state_e {IDLE, DRIVE, WAIT, CHECK, DONE};
  - constant DFG_VEC_COUNT = 8;
  - function dfg_golden(logic [2:0] abc) returning logic [2:0] {p,q,r}.
- No sub-module. The golden model is the package function, so the checker does not depend on the gate under test.
- The settle counter is sized $clog2(SETTLE_CYCLES+1), minimum 1 bit.

Test Plan:
1. Reset: hold rst_n=0 with start=1 -> all outputs 0, busy=0, done=0. Release rst_n -> first start edge enters DRIVE with abc=000.
2. Correct gate connected, SETTLE_CYCLES=1, pulse start -> abc steps 000..111, 3 cycles each. done=1 exactly 24 edges after start; pass=1, err_count=0, first_fail_valid=0.
3. Faulty gate with q stuck at 0 -> 4 mismatches (vectors 010, 011, 100, 101). done: pass=0, err_count=4, first_fail_vec=3'b010.
4. ERR_W=2, all gate outputs inverted -> 8 mismatches. err_count saturates at 3; first_fail_vec=000; pass=0.
5. Pulse start while in WAIT for vector 011 -> no restart; the run completes at the normal 24-edge time. A later start in DONE restarts and clears err_count within one edge.
6. Assert rst_n=0 asynchronously mid-run (between edges, vector 101) -> outputs drop to 0 immediately without a clock edge. SETTLE_CYCLES=0 run: done rises 16 edges after start.
